frame_buffer_arbiter: RTL

Owns the read/write port of the 32768x1 video frame buffer. Single writer to that port; the display scan keeps the read-only port.
- Accepts single-pixel writes from the processor bus through a small FIFO.
- Runs a full-screen fill/clear engine.
- Sequences both so every queued pixel write lands before a fill starts, and no pixel write is lost or reordered.

---
 rtl/frame_buffer_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter
//   Sole owner of the read/write port of the 32768x1 frame buffer. It merges
//   single-pixel writes from the processor bus, buffered in a small FIFO, with
//   a full-screen fill engine. Every queued pixel write is retired, in order,
//   before a fill begins.
//
// Ports
//   CLK, RESET             clock (rising edge), asynchronous active-low reset
//   PIX_WR/X/Y/DATA        pixel write request; accepted when PIX_FULL=0
//   PIX_FULL               registered backpressure (FIFO full or fill pending/active)
//   FILL_START/FILL_VALUE  fill request; only sampled in IDLE, value latched on accept
//   FILL_BUSY              high while a flush or a fill is in progress
//   FILL_DONE              one-cycle pulse after the last fill write
//   FB_ADDR/FB_DATA_OUT/FB_WE  registered frame buffer write port
module frame_buffer_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int X_W        = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PIX_WR,
    input  logic [X_W-1:0]        PIX_X,
    input  logic [ADDR_W-X_W-1:0] PIX_Y,
    input  logic                  PIX_DATA,
    output logic                  PIX_FULL,
    input  logic                  FILL_START,
    input  logic                  FILL_VALUE,
    output logic                  FILL_BUSY,
    output logic                  FILL_DONE,
    output logic [ADDR_W-1:0]     FB_ADDR,
    output logic                  FB_DATA_OUT,
    output logic                  FB_WE
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FLUSH, FILL} state_t;

    state_t               state, state_nxt;
    logic [ADDR_W:0]      mem [FIFO_DEPTH];   // {Y, X, DATA}
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    // One extra bit so the counter can sit at 2**ADDR_W for the cycle after
    // the last write; that is what tells FILL the sweep is finished.
    logic [ADDR_W:0]      fill_cnt;
    logic                 fill_val;
    logic                 push, pop;

    // PIX_FULL is registered, so a push is judged against the current flag;
    // a pop in the same cycle does not free a slot for a full FIFO.
    assign push = PIX_WR && !PIX_FULL;
    assign pop  = (cnt != '0) && (state == IDLE || state == FLUSH);

    always_comb begin
        cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // Fill start looks at the post-edge count, so a pixel accepted in
            // the same cycle as FILL_START forces a flush ahead of the fill.
            IDLE:    if (FILL_START) state_nxt = (cnt_nxt == '0) ? FILL : FLUSH;
            FLUSH:   if (cnt == '0)  state_nxt = FILL;
            FILL:    if (fill_cnt[ADDR_W]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage carries no reset; occupancy is tracked by cnt.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {PIX_Y, PIX_X, PIX_DATA};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            fill_cnt    <= '0;
            fill_val    <= 1'b0;
            PIX_FULL    <= 1'b0;
            FILL_BUSY   <= 1'b0;
            FILL_DONE   <= 1'b0;
            FB_ADDR     <= '0;
            FB_DATA_OUT <= 1'b0;
            FB_WE       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            PIX_FULL  <= (cnt_nxt == CNT_W'(FIFO_DEPTH)) || (state_nxt != IDLE);
            FILL_BUSY <= (state_nxt != IDLE);
            FILL_DONE <= 1'b0;
            FB_WE     <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                FB_ADDR     <= mem[rd_ptr][ADDR_W:1];
                FB_DATA_OUT <= mem[rd_ptr][0];
                FB_WE       <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (FILL_START) begin
                        fill_val <= FILL_VALUE;
                        fill_cnt <= '0;
                    end
                end
                FLUSH: begin
                    // The FLUSH->FILL edge issues no write: one idle cycle.
                    if (cnt == '0) fill_cnt <= '0;
                end
                FILL: begin
                    if (fill_cnt[ADDR_W]) begin
                        FILL_DONE <= 1'b1;
                    end else begin
                        FB_ADDR     <= fill_cnt[ADDR_W-1:0];
                        FB_DATA_OUT <= fill_val;
                        FB_WE       <= 1'b1;
                        fill_cnt    <= fill_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
